bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Two-master, N-slave arbiter and address decoder for the shared system bus. Master 0 is the core data port; master 1 is a second bus master (DMA/debug). The block selects one owner per transaction by round-robin and registers that owner's request onto the bus. It decodes the address into the one-hot o_BUS_CE chip-enables and routes the slave GNT/RDATA back to the owner. Unmapped accesses and slaves that never respond are terminated with an error instead of hanging the bus.

Parameters:
N_SLAVES, 4, number of decoded slaves (1..8); o_BUS_CE bits at and above N_SLAVES stay 0
SEL_LSB, 28, slave index = ADDR[SEL_LSB+2:SEL_LSB]
TIMEOUT, 255, cycles in BUSY without i_BUS_GNT before the transaction is aborted (1..65535)

Ports:
i_CLK  in  1  clock
i_RSTn  in  1  asynchronous reset, active low
i_M0_REQ / i_M1_REQ  in  1  master request, held until its GNT
i_M0_ADDR / i_M1_ADDR  in  32  byte address
i_M0_WDATA / i_M1_WDATA  in  32  write data
i_M0_WE / i_M1_WE  in  1  1=write, 0=read
i_M0_HB / i_M1_HB  in  2  size code, passed through unchanged
o_M0_GNT / o_M1_GNT  out  1  one-cycle completion pulse
o_M0_RDATA / o_M1_RDATA  out  32  read data, valid with GNT
o_M0_ERR / o_M1_ERR  out  1  error flag, valid with GNT
o_BUS_ADDR  out  32  registered address
o_BUS_WDATA  out  32  registered write data
o_BUS_WE / o_BUS_RE  out  1  registered write / read strobe
o_BUS_HB  out  2  registered size
o_BUS_REQ  out  1  bus request
o_BUS_CE  out  8  one-hot slave select
i_BUS_GNT  in  1  OR of slave grants, one-cycle pulse
i_BUS_RDATA  in  32  muxed slave read data

Behaviour:
- Reset, asynchronous: state=IDLE, last_owner=M1 (M0 wins the first tie), timeout counter=0. All o_BUS_* outputs, o_Mx_GNT, o_Mx_ERR and o_Mx_RDATA are 0.
- Reset asserted mid-transaction aborts the transaction; no GNT is issued to either master.
- FSM states: IDLE, BUSY, ERR.
- IDLE behaviour:
  - No request: outputs stay 0.
  - Exactly one REQ: that master becomes owner.
  - Both REQ: owner = the master that is not last_owner.
  - Mapped index (idx < N_SLAVES): on the next edge, register ADDR/WDATA/WE/HB. Set o_BUS_REQ=1, o_BUS_RE=~WE, o_BUS_WE=WE, o_BUS_CE=1<<idx, go to BUSY.
  - Unmapped index: go to ERR without any bus activity.
- BUSY behaviour:
  - Bus outputs are held and the counter increments each cycle.
  - On i_BUS_GNT=1 (combinational forward, same cycle): o_owner_GNT=1, o_owner_RDATA=i_BUS_RDATA, o_owner_ERR=0.
  - On the edge after GNT: clear all bus outputs, last_owner<=owner, counter<=0, go to IDLE.
  - Counter reaching TIMEOUT with no GNT: clear bus outputs, go to ERR.
  - GNT in the same cycle as expiry: GNT wins and is a normal completion.
- ERR behaviour: for one cycle, o_owner_GNT=1, o_owner_ERR=1, o_owner_RDATA=0. Then last_owner<=owner and go to IDLE.
- Latency: request sampled in IDLE at cycle t, o_BUS_REQ high at t+1, master GNT in the same cycle as i_BUS_GNT. Minimum transaction is 2 cycles. There is at least one IDLE cycle between transactions, so a master may re-request in the cycle after its GNT.
- o_Mx_RDATA/o_Mx_ERR are 0 whenever the matching GNT is 0. The non-owner never sees GNT.
- i_BUS_GNT while in IDLE or ERR is ignored.
- A master lowering REQ before its GNT is a protocol violation. The issued transaction still completes.

Decomposition:
- Shared package bus_pkg holds:
  - FSM state encodings (IDLE/BUSY/ERR)
  - master index constants M0/M1
  - slave index constants (ROM=0, SRAM=1, UART=2, TIMER=3)
  - SEL_LSB default
- One sub-module is natural: bus_addr_decode. It is combinational: ADDR → one-hot CE[7:0] plus a mapped flag, parameterised by N_SLAVES and SEL_LSB.
- The FSM, round-robin pointer, timeout counter and output registers stay in bus_arbiter.

Test Plan:
1. M0 read addr 0x1000_0040, slave asserts GNT with RDATA 0xDEADBEEF 3 cycles after o_BUS_REQ → o_BUS_CE=0x02, o_BUS_RE=1, o_M0_GNT one pulse with RDATA 0xDEADBEEF, ERR=0; o_M1_GNT stays 0.
2. M0 and M1 request together from reset, each re-requesting right after its GNT, 4 transactions → owners in order M0, M1, M0, M1.
3. M1 write 0x2000_0000, WDATA 0x41, WE=1 → o_BUS_CE=0x04, o_BUS_WE=1, o_BUS_WDATA=0x41 held until GNT; bus outputs 0 on the following cycle.
4. M0 access to 0x7000_0000 with N_SLAVES=4 → no o_BUS_REQ; o_M0_GNT and o_M0_ERR pulse one cycle, 2 cycles after REQ.
5. TIMEOUT=8, slave never grants → o_BUS_REQ high exactly 8 cycles, then o_M0_GNT=1 with ERR=1. Repeat with GNT on cycle 8 → normal completion, ERR=0.
6. i_RSTn low while in BUSY → all outputs 0 immediately. After release, a pending M1 request is served first-tie-correctly (M0 wins if both request).

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared state encodings, master/slave indices and decode defaults
// for the two-master system bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int SLV_ROM   = 0;
    localparam int SLV_SRAM  = 1;
    localparam int SLV_UART  = 2;
    localparam int SLV_TIMER = 3;

    localparam int SEL_LSB_DEF = 28;

endpackage

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: maps a byte address to a one-hot slave chip-enable and
// flags whether the selected slave index exists.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int SEL_LSB  = SEL_LSB_DEF
) (
    input  logic [31:0] addr_i,
    output logic [7:0]  ce_o,
    output logic        mapped_o
);

    logic [2:0] idx;

    assign idx      = 3'(addr_i >> SEL_LSB);
    assign mapped_o = 32'(idx) < N_SLAVES;
    assign ce_o     = mapped_o ? 8'(1) << idx : 8'h00;

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter between two masters onto a shared slave bus,
// with address decode, bus timeout and error termination of unmapped accesses.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int SEL_LSB  = SEL_LSB_DEF,
    parameter int TIMEOUT  = 255
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic        i_M0_REQ,
    input  logic [31:0] i_M0_ADDR,
    input  logic [31:0] i_M0_WDATA,
    input  logic        i_M0_WE,
    input  logic [1:0]  i_M0_HB,
    output logic        o_M0_GNT,
    output logic [31:0] o_M0_RDATA,
    output logic        o_M0_ERR,
    input  logic        i_M1_REQ,
    input  logic [31:0] i_M1_ADDR,
    input  logic [31:0] i_M1_WDATA,
    input  logic        i_M1_WE,
    input  logic [1:0]  i_M1_HB,
    output logic        o_M1_GNT,
    output logic [31:0] o_M1_RDATA,
    output logic        o_M1_ERR,
    output logic [31:0] o_BUS_ADDR,
    output logic [31:0] o_BUS_WDATA,
    output logic        o_BUS_WE,
    output logic        o_BUS_RE,
    output logic [1:0]  o_BUS_HB,
    output logic        o_BUS_REQ,
    output logic [7:0]  o_BUS_CE,
    input  logic        i_BUS_GNT,
    input  logic [31:0] i_BUS_RDATA
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic        owner_q, last_q;
    logic [15:0] cnt_q;
    logic [31:0] addr_q, wdata_q;
    logic        we_q, re_q, req_q;
    logic [1:0]  hb_q;
    logic [7:0]  ce_q;

    logic        req_any, own_d, mapped_d, we_d, fwd, err;
    logic [31:0] addr_d, wdata_d;
    logic [1:0]  hb_d;
    logic [7:0]  ce_d;

    // On a tie the master that did not own the previous transaction wins.
    assign req_any = i_M0_REQ | i_M1_REQ;
    assign own_d   = (i_M0_REQ & i_M1_REQ) ? ~last_q : i_M1_REQ;
    assign addr_d  = own_d ? i_M1_ADDR  : i_M0_ADDR;
    assign wdata_d = own_d ? i_M1_WDATA : i_M0_WDATA;
    assign we_d    = own_d ? i_M1_WE    : i_M0_WE;
    assign hb_d    = own_d ? i_M1_HB    : i_M0_HB;

    bus_addr_decode #(
        .N_SLAVES(N_SLAVES),
        .SEL_LSB (SEL_LSB)
    ) u_dec (
        .addr_i  (addr_d),
        .ce_o    (ce_d),
        .mapped_o(mapped_d)
    );

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= IDLE;
            owner_q <= M0;
            last_q  <= M1;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            req_q   <= 1'b0;
            hb_q    <= '0;
            ce_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_any) begin
                    owner_q <= own_d;
                    state_q <= mapped_d ? BUSY : ERR;
                    if (mapped_d) begin
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        we_q    <= we_d;
                        re_q    <= ~we_d;
                        hb_q    <= hb_d;
                        ce_q    <= ce_d;
                        req_q   <= 1'b1;
                    end
                end
                // A grant arriving on the expiry cycle still completes normally.
                BUSY: if (i_BUS_GNT || cnt_q == CNT_LAST) begin
                    addr_q  <= '0;
                    wdata_q <= '0;
                    we_q    <= 1'b0;
                    re_q    <= 1'b0;
                    hb_q    <= '0;
                    ce_q    <= '0;
                    req_q   <= 1'b0;
                    cnt_q   <= '0;
                    if (i_BUS_GNT) last_q <= owner_q;
                    state_q <= i_BUS_GNT ? IDLE : ERR;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                ERR: begin
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fwd = (state_q == BUSY) & i_BUS_GNT;
    assign err = state_q == ERR;

    assign o_M0_GNT   = (fwd | err) & (owner_q == M0);
    assign o_M0_ERR   = err & (owner_q == M0);
    assign o_M0_RDATA = (fwd && owner_q == M0) ? i_BUS_RDATA : '0;
    assign o_M1_GNT   = (fwd | err) & (owner_q == M1);
    assign o_M1_ERR   = err & (owner_q == M1);
    assign o_M1_RDATA = (fwd && owner_q == M1) ? i_BUS_RDATA : '0;

    assign o_BUS_ADDR  = addr_q;
    assign o_BUS_WDATA = wdata_q;
    assign o_BUS_WE    = we_q;
    assign o_BUS_RE    = re_q;
    assign o_BUS_HB    = hb_q;
    assign o_BUS_REQ   = req_q;
    assign o_BUS_CE    = ce_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vector table, round-robin/timeout/reset sequences and
// randomized transactions checked against a transaction-level arbiter model.
module tb_bus_arbiter;

    localparam int TO = 8;
    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  m_req, m_we, gnt_w, err_w;
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    logic [1:0]  m_hb   [2];
    logic [31:0] rd_w   [2];
    logic [31:0] bus_addr, bus_wdata, bus_rd;
    logic        bus_we, bus_re, bus_req, bus_gnt;
    logic [1:0]  bus_hb;
    logic [7:0]  bus_ce;

    int   total = 0;
    int   bad = 0;
    logic last;
    logic served;

    typedef struct {
        logic        m;
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        logic [1:0]  hb;
        int          g;
        logic [31:0] rd;
        logic [7:0]  ce;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    bus_arbiter #(.N_SLAVES(NS), .SEL_LSB(28), .TIMEOUT(TO)) dut (
        .i_CLK(clk), .i_RSTn(rstn),
        .i_M0_REQ(m_req[0]), .i_M0_ADDR(m_addr[0]), .i_M0_WDATA(m_wd[0]),
        .i_M0_WE(m_we[0]), .i_M0_HB(m_hb[0]),
        .o_M0_GNT(gnt_w[0]), .o_M0_RDATA(rd_w[0]), .o_M0_ERR(err_w[0]),
        .i_M1_REQ(m_req[1]), .i_M1_ADDR(m_addr[1]), .i_M1_WDATA(m_wd[1]),
        .i_M1_WE(m_we[1]), .i_M1_HB(m_hb[1]),
        .o_M1_GNT(gnt_w[1]), .o_M1_RDATA(rd_w[1]), .o_M1_ERR(err_w[1]),
        .o_BUS_ADDR(bus_addr), .o_BUS_WDATA(bus_wdata), .o_BUS_WE(bus_we),
        .o_BUS_RE(bus_re), .o_BUS_HB(bus_hb), .o_BUS_REQ(bus_req),
        .o_BUS_CE(bus_ce), .i_BUS_GNT(bus_gnt), .i_BUS_RDATA(bus_rd)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_bus_ctl"}, {bus_req, bus_we, bus_re, bus_hb, bus_ce}, 0);
        chk({nm, "_bus_addr"}, bus_addr, 0);
        chk({nm, "_bus_wdata"}, bus_wdata, 0);
        chk({nm, "_m_flags"}, {gnt_w, err_w}, 0);
        chk({nm, "_m_rdata"}, {rd_w[0], rd_w[1]}, 0);
    endtask

    task automatic chk_m(input logic own, input logic g, input logic [31:0] rd, input logic e);
        int o, x;
        o = int'(own);
        x = 1 - o;
        chk("own_gnt", gnt_w[o], g);
        chk("own_rdata", rd_w[o], rd);
        chk("own_err", err_w[o], e);
        chk("other_quiet", {gnt_w[x], err_w[x], rd_w[x]}, 0);
    endtask

    task automatic set_m(input int m, input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input logic [1:0] hb);
        m_req[m]  = 1'b1;
        m_addr[m] = a;
        m_we[m]   = we;
        m_wd[m]   = wd;
        m_hb[m]   = hb;
    endtask

    // Entered just after a clock edge with the arbiter idle and requests driven;
    // returns just after the edge that ends the completion cycle.
    task automatic run_txn(input int g, input logic [31:0] rd, input logic own,
                           input logic [7:0] ce, input logic mp, input logic [31:0] a,
                           input logic [31:0] wd, input logic we, input logic [1:0] hb);
        logic done;
        done = 1'b0;
        @(negedge clk);
        chk_quiet("idle");
        tick();
        if (mp) begin
            for (int k = 1; k <= TO && !done; k++) begin
                if (k == g) begin
                    bus_gnt = 1'b1;
                    bus_rd  = rd;
                end
                @(negedge clk);
                chk("bus_ctl", {bus_req, bus_we, bus_re, bus_hb, bus_ce}, {1'b1, we, ~we, hb, ce});
                chk("bus_addr", bus_addr, a);
                chk("bus_wdata", bus_wdata, wd);
                chk_m(own, k == g, (k == g) ? rd : 32'h0, 1'b0);
                tick();
                bus_gnt = 1'b0;
                bus_rd  = $urandom;
                done    = (k == g);
            end
        end
        if (!done) begin
            @(negedge clk);
            chk("err_bus_ctl", {bus_req, bus_we, bus_re, bus_hb, bus_ce}, 0);
            chk_m(own, 1'b1, 32'h0, 1'b1);
            tick();
        end
    endtask

    // Transaction-level model: pick the owner from pending requests and the
    // previous owner, decode the slave from the address arithmetically.
    task automatic serve(input int g, input logic [31:0] rd);
        logic own;
        int   idx;
        logic mp;
        own = (m_req[0] && m_req[1]) ? ~last : m_req[1];
        idx = int'(m_addr[own] / 32'h1000_0000) % 8;
        mp  = idx < NS;
        run_txn(g, rd, own, mp ? 8'(2 ** idx) : 8'h00, mp, m_addr[own], m_wd[own], m_we[own], m_hb[own]);
        last = own;
        served = own;
        m_req[own] = 1'b0;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        m_req   = '0;
        bus_gnt = 1'b0;
        last    = 1'b1;
        #1;
        chk_quiet("reset");
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 32'h1000_0040, 1'b0, 32'h0000_1111, 2'd2, 4, 32'hDEAD_BEEF, 8'h02};
        tbl[1] = '{1'b1, 32'h2000_0000, 1'b1, 32'h0000_0041, 2'd0, 2, 32'h1234_5678, 8'h04};
        tbl[2] = '{1'b0, 32'h7000_0000, 1'b0, 32'h0000_0000, 2'd0, 1, 32'hFFFF_FFFF, 8'h00};
        tbl[3] = '{1'b0, 32'h0000_1234, 1'b0, 32'hA5A5_A5A5, 2'd1, 1, 32'hCAFE_F00D, 8'h01};
        tbl[4] = '{1'b1, 32'h3FFF_FFFC, 1'b1, 32'h5555_AAAA, 2'd3, 8, 32'h0BAD_CAFE, 8'h08};
        tbl[5] = '{1'b0, 32'h3000_0000, 1'b0, 32'h0000_0000, 2'd2, 9, 32'h1111_2222, 8'h08};
        tbl[6] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0000_0007, 2'd1, 1, 32'h7777_0000, 8'h01};
        tbl[7] = '{1'b1, 32'h4000_0000, 1'b1, 32'h0000_0009, 2'd0, 3, 32'h0000_0001, 8'h00};
        tbl[8] = '{1'b0, 32'hF000_0000, 1'b1, 32'h0000_000A, 2'd0, 3, 32'h0000_0002, 8'h00};
        m_we = '0;
        for (int m = 0; m < 2; m++) begin
            m_addr[m] = '0;
            m_wd[m]   = '0;
            m_hb[m]   = '0;
        end
        bus_rd = $urandom;
        do_reset();

        for (int i = 0; i < 9; i++) begin
            m_req = '0;
            set_m(int'(tbl[i].m), tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].hb);
            run_txn(tbl[i].g, tbl[i].rd, tbl[i].m, tbl[i].ce, tbl[i].ce != 8'h00,
                    tbl[i].a, tbl[i].wd, tbl[i].we, tbl[i].hb);
            last = tbl[i].m;
            m_req[tbl[i].m] = 1'b0;
        end
        @(negedge clk);
        chk_quiet("after_table");
        tick();

        do_reset();
        set_m(0, 32'h1000_0000, 1'b0, 32'h0, 2'd2);
        set_m(1, 32'h0000_0100, 1'b1, 32'h55, 2'd0);
        for (int i = 0; i < 4; i++) begin
            serve(2, $urandom);
            chk("rr_owner", served, i % 2);
            set_m(int'(served), served ? 32'h0000_0100 : 32'h1000_0000 + i, served, 32'h55, 2'd1);
        end

        do_reset();
        set_m(1, 32'h1000_0000, 1'b0, 32'h0, 2'd2);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("busy_before_rst", bus_req, 1);
        tick();
        bus_gnt = 1'b1;
        bus_rd  = 32'h9999_9999;
        rstn    = 1'b0;
        #1;
        chk_quiet("rst_abort");
        bus_gnt = 1'b0;
        last    = 1'b1;
        set_m(0, 32'h2000_0010, 1'b1, 32'h77, 2'd0);
        repeat (2) tick();
        rstn = 1'b1;
        serve(1, 32'h0101_0101);
        chk("post_rst_first", served, 0);
        serve(2, 32'h0202_0202);
        chk("post_rst_second", served, 1);

        do_reset();
        for (int t = 0; t < 150; t++) begin
            for (int m = 0; m < 2; m++)
                if (!m_req[m] && $urandom_range(0, 1) == 1)
                    set_m(m, $urandom, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)));
            if (m_req == 2'b00)
                set_m(0, $urandom, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)));
            serve(int'($urandom_range(1, TO + 2)), $urandom);
        end
        m_req = '0;
        @(negedge clk);
        chk_quiet("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
